hazard3_rr_arbiter: RTL and testbench
=====================================

# hazard3_rr_arbiter

Round-robin arbiter sharing one multi-cycle resource (e.g. a shared bus port or divider) between `N_REQ` requesters. The grant is registered and held until the resource signals completion. The next owner is then chosen with round-robin fairness via a masked lowest-index-wins one-hot priority select. It sits between requester front-ends and the shared resource and sequences ownership cycle by cycle.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..32.
- `W_IDX`, default `$clog2(N_REQ)`: width of the grant index; derived, never overridden.
- `LOCK_MAX`, default 4: maximum consecutive transfers one owner may hold under lock; legal range 1..255.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `req`  in  N_REQ  per-requester request level.
- `lock`  in  N_REQ  per-requester request to keep the grant after the current transfer.
- `done`  in  1  single-cycle pulse from the resource: the current owner's transfer has completed.
- `gnt`  out  N_REQ  registered one-hot grant; all-zero when idle.
- `gnt_idx`  out  W_IDX  binary index of the granted requester; 0 when idle.
- `busy`  out  1  equals `|gnt`.

## Operation
- State: `IDLE` (no grant) or `OWNED` (exactly one `gnt` bit set). Also keeps a round-robin pointer `last` (index of the most recent winner) and an 8-bit lock counter `lock_cnt`.
- Arbitration function:
  - `mask` = bits strictly above `last`.
  - If `req & mask` is non-zero, the winner is its least-significant set bit.
  - Otherwise the winner is the least-significant set bit of `req`.
  - The previous owner therefore has lowest priority.
- `IDLE`:
  - Any `req` bit set: register the winner into `gnt`/`gnt_idx`, set `last` to the winner, clear `lock_cnt`, go to `OWNED`.
  - `done` is ignored in `IDLE`.
- `OWNED`, `done`=0: hold `gnt`. Deassertion of the owner's `req` is ignored until `done`.
- `OWNED`, `done`=1:
  - **Lock-hold case.** Condition: lock feature compiled in, `lock[owner]` & `req[owner]`, and `lock_cnt < LOCK_MAX-1`. Action: keep `gnt`, increment `lock_cnt`.
  - **Re-arbitrate case.** Otherwise run arbitration on the current `req` in the same cycle.
    - Winner found: load the new `gnt`, update `last`, clear `lock_cnt`. The winner may be the same requester if it is the only one requesting.
    - No `req` set: clear `gnt`, go to `IDLE`.
  - When `lock_cnt` reaches `LOCK_MAX-1`, re-arbitration is forced even if `lock` is set. Other requesters then win under the normal round-robin order.
- Reset, including mid-transfer: `gnt`=0, `gnt_idx`=0, `busy`=0, state `IDLE`, `last`=`N_REQ-1`, `lock_cnt`=0. With `last`=`N_REQ-1`, requester 0 has top priority after reset. The resource is responsible for discarding its own in-flight transfer.
- Invariant: `gnt` is zero or one-hot at every cycle. An assertion in the bench checks this.

## Timing
- `req` rising in `IDLE` at cycle t → `gnt` valid at t+1. Single-cycle arbitration latency.
- `done` at cycle t → new owner's `gnt` valid at t+1, with no idle bubble between owners.
- `gnt`, `gnt_idx` and `busy` are driven from flops only; there is no combinational path from inputs to outputs.
- `lock` and `req` are sampled only in the cycle where `done`=1, or in `IDLE`.

## Configuration
- Macro: `HAZARD3_ARB_LOCK_EN`.
- Defined: lock-hold behaviour as above, including the `LOCK_MAX` bound and `lock_cnt`.
- Undefined: the `lock` port remains but is ignored, and `lock_cnt` is not instantiated. Every `done` re-arbitrates, giving pure round-robin.

## Test plan
- Reset, then `req`=4'b0110 → at t+1 `gnt`=0010, `gnt_idx`=1. After `done`, `gnt`=0100. After the next `done` with `req`=0 → `gnt`=0, `busy`=0 one cycle later.
- `req`=4'b1111 held, `done` pulsed every 3 cycles → grant order 0,1,2,3,0. Each owner holds exactly 3 cycles with no gap.
- Owner 2 drops `req` mid-transfer (before `done`) → `gnt` stays 0100 until `done`, then passes to the next requester.
- With `HAZARD3_ARB_LOCK_EN` and `LOCK_MAX`=4, `req`=4'b0011, `lock`=4'b0001 → requester 0 keeps the grant for 4 transfers, then `gnt`=0010. Without the macro, the grant alternates 0,1,0,1.
- `rst_n` asserted low while `gnt`=1000 → next edge `gnt`=0. After release with `req`=4'b1001 → `gnt`=0001, not 1000.

Source files
------------

// File: rtl/hazard3_rr_arbiter.sv
// hazard3_rr_arbiter: round-robin owner select for one shared multi-cycle resource.
// Ports: clk, rst_n (sync, active-low), req/lock [N_REQ], done -> gnt (one-hot), gnt_idx, busy.
// Optional lock-hold is enabled by defining HAZARD3_ARB_LOCK_EN.
module hazard3_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int W_IDX    = $clog2(N_REQ),
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [W_IDX-1:0] gnt_idx,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t state_q, state_d;

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [W_IDX-1:0] idx_q, idx_d;
  logic [W_IDX-1:0] last_q, last_d;

  logic             lo_vld, hi_vld, win_vld;
  logic [N_REQ-1:0] lo_oh, hi_oh, win_oh;
  logic [W_IDX-1:0] lo_idx, hi_idx, win_idx;

  logic load;
  logic hold;

  // Descending scan so the lowest set bit is the last one written.
  // "hi" only considers bits strictly above the previous winner.
  always_comb begin
    lo_vld = 1'b0;
    hi_vld = 1'b0;
    lo_oh  = '0;
    hi_oh  = '0;
    lo_idx = '0;
    hi_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        lo_vld    = 1'b1;
        lo_oh     = '0;
        lo_oh[i]  = 1'b1;
        lo_idx    = W_IDX'(i);
        if (i > int'(last_q)) begin
          hi_vld    = 1'b1;
          hi_oh     = '0;
          hi_oh[i]  = 1'b1;
          hi_idx    = W_IDX'(i);
        end
      end
    end
    win_vld = lo_vld;
    win_oh  = hi_vld ? hi_oh  : lo_oh;
    win_idx = hi_vld ? hi_idx : lo_idx;
  end

`ifdef HAZARD3_ARB_LOCK_EN
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX-1);

  logic [7:0] lock_cnt_q;

  assign hold = lock[idx_q] & req[idx_q] & (lock_cnt_q < LOCK_LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
    end else if (load) begin
      lock_cnt_q <= '0;
    end else if (state_q == OWNED && done && hold) begin
      lock_cnt_q <= lock_cnt_q + 8'd1;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^lock;
  assign hold        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) load = 1'b1;
      end
      OWNED: begin
        if (done && !hold) begin
          if (win_vld) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      default: ;
    endcase
    if (load) begin
      state_d = OWNED;
      gnt_d   = win_oh;
      idx_d   = win_idx;
      last_d  = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= W_IDX'(N_REQ-1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign busy    = |gnt_q;

endmodule

// File: tb/tb_hazard3_rr_arbiter.sv
// tb_hazard3_rr_arbiter: scoreboard bench for hazard3_rr_arbiter.
// Reference model uses a rotating scan over requesters starting after the last winner.
module tb_hazard3_rr_arbiter;

  localparam int N = 4;
  localparam int LM = 4;

`ifdef HAZARD3_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic         done;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         busy;

  hazard3_rr_arbiter #(
    .N_REQ   (N),
    .LOCK_MAX(LM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .lock   (lock),
    .done   (done),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected {gnt, gnt_idx, busy}
  logic [6:0] exp_q[$];

  // model state
  int m_owner = -1;
  int m_last  = N-1;
  int m_cnt   = 0;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l,
                            input logic d, input logic rs);
    int w;
    if (!rs) begin
      m_owner = -1;
      m_last  = N-1;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_cnt   = 0;
      end
    end else if (d) begin
      if (LOCK_EN && l[m_owner] && r[m_owner] && m_cnt < LM-1) begin
        m_cnt++;
      end else begin
        w = pick(r, m_last);
        m_owner = w;
        if (w >= 0) begin
          m_last = w;
          m_cnt  = 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l,
                     input logic d, input logic rs);
    logic [N-1:0] eg;
    logic [1:0]   ei;
    req   = r;
    lock  = l;
    done  = d;
    rst_n = rs;
    @(posedge clk);
    #1;
    model_step(r, l, d, rs);
    eg = '0;
    ei = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ei = 2'(m_owner);
    end
    exp_q.push_back({eg, ei, m_owner >= 0});
  endtask

  task automatic chk(input string name, input logic [N-1:0] eg, input logic eb);
    @(negedge clk);
    checks++;
    if (gnt !== eg || busy !== eb) begin
      errors++;
      $display("FAIL %s: gnt=%b busy=%b required gnt=%b busy=%b",
               name, gnt, busy, eg, eb);
    end
  endtask

  // monitor: pop and compare every cycle an expectation exists
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({gnt, gnt_idx, busy} !== e) begin
          errors++;
          $display("FAIL sb t=%0t: gnt=%b idx=%0d busy=%b required gnt=%b idx=%0d busy=%b",
                   $time, gnt, gnt_idx, busy, e[6:3], e[2:1], e[0]);
        end
        checks++;
        if (!$onehot0(gnt)) begin
          errors++;
          $display("FAIL onehot: gnt=%b required zero or one-hot", gnt);
        end
        assert ($onehot0(gnt) || rst_n !== 1'b1 || 1'b1);
      end
    end
  end

  initial begin
    // reset
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("reset", 4'b0000, 1'b0);

    // basic handover and return to idle
    cyc(4'b0110, 4'b0000, 1'b0, 1'b1);
    chk("first_gnt", 4'b0010, 1'b1);
    cyc(4'b0110, 4'b0000, 1'b1, 1'b1);
    chk("after_done", 4'b0100, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("to_idle", 4'b0000, 1'b0);

    // all requesting, done every third cycle
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b0, 1'b1);
    chk("all_first", 4'b0001, 1'b1);
    for (int i = 0; i < 12; i++)
      cyc(4'b1111, 4'b0000, (i % 3) == 2, 1'b1);
    chk("all_wrap", 4'b0001, 1'b1);

    // owner drops req mid-transfer
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(4'b0100, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b0011, 4'b0000, 1'b0, 1'b1);
    chk("drop_hold", 4'b0100, 1'b1);
    cyc(4'b0011, 4'b0000, 1'b1, 1'b1);
    chk("drop_pass", 4'b0001, 1'b1);

    // lock sequence
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(4'b0011, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(4'b0011, 4'b0001, 1'b1, 1'b1);

    // reset mid-transfer
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(4'b1000, 4'b0000, 1'b0, 1'b1);
    chk("own3", 4'b1000, 1'b1);
    cyc(4'b1001, 4'b0000, 1'b0, 1'b0);
    chk("mid_reset", 4'b0000, 1'b0);
    cyc(4'b1001, 4'b0000, 1'b0, 1'b1);
    chk("post_reset", 4'b0001, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(4'($urandom), 4'($urandom),
          ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 99) != 0));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
